// File: rtl/fc_result_argmax.sv
// fc_result_argmax: collects one frame of signed FC class scores, tracks the
// running argmax and presents the winner plus the buffered scores to the SPI
// readout through a valid/ack handshake.
// Optional build macro ARGMAX_MARGIN_EN adds oMARGIN (best minus second-best).
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for the first score of a frame
// COLLECT | scores 1..oLEN-1 received, more expected
// HOLD    | result valid on oVALID/oCLASS/oMAX, awaiting iACK
module fc_result_argmax #(
    parameter int WLc  = 13,
    parameter int oLEN = 5,
    parameter int IDXW = 3
) (
    input  logic            iCLK,
    input  logic            iRSTn,
    input  logic            iCLR,
    input  logic            iVALID,
    input  logic [WLc-1:0]  iDATA,
    input  logic            iACK,
    input  logic [IDXW-1:0] iRADDR,
    output logic [WLc-1:0]  oRDATA,
    output logic            oVALID,
    output logic [IDXW-1:0] oCLASS,
    output logic [WLc-1:0]  oMAX,
    output logic            oBUSY,
    output logic            oOVF
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [WLc:0]    oMARGIN
`endif
);

    // cnt must be able to hold oLEN itself, hence one extra bit
    localparam int CNTW = IDXW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [WLc-1:0]         score_buf [oLEN];
    logic [CNTW-1:0]        cnt;
    logic signed [WLc-1:0]  run_max;
    logic [IDXW-1:0]        run_idx;

    logic                   start_frame;
    logic                   accept;
    logic                   frame_done;
    logic                   ack_take;
    logic                   ovf_set;
    logic                   new_gt;
    logic signed [WLc-1:0]  fin_max;
    logic [IDXW-1:0]        fin_idx;

    assign new_gt  = $signed(iDATA) > run_max;
    assign fin_max = (start_frame || new_gt) ? $signed(iDATA) : run_max;
    assign fin_idx = start_frame ? '0 : (new_gt ? cnt[IDXW-1:0] : run_idx);
    assign oBUSY   = (state == ST_COLLECT);

`ifdef ARGMAX_MARGIN_EN
    localparam logic signed [WLc-1:0] SCORE_MIN = {1'b1, {(WLc-1){1'b0}}};

    logic signed [WLc-1:0]  run_sec;
    logic signed [WLc-1:0]  fin_sec;
    logic [WLc:0]           fin_margin;

    // a single-score frame compares the winner with itself, giving margin 0
    assign fin_sec    = start_frame ? $signed(iDATA) :
                        new_gt ? run_max :
                        ($signed(iDATA) > run_sec) ? $signed(iDATA) : run_sec;
    assign fin_margin = {fin_max[WLc-1], fin_max} - {fin_sec[WLc-1], fin_sec};
`endif

    // state register
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next-state and datapath strobes; clear beats everything else
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        accept      = 1'b0;
        frame_done  = 1'b0;
        ack_take    = 1'b0;
        ovf_set     = 1'b0;
        if (iCLR) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iVALID) begin
                        start_frame = 1'b1;
                        frame_done  = (oLEN == 1);
                        state_nxt   = (oLEN == 1) ? ST_HOLD : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (iVALID) begin
                        accept = 1'b1;
                        if (cnt == CNTW'(oLEN - 1)) begin
                            frame_done = 1'b1;
                            state_nxt  = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (iACK) begin
                        ack_take  = 1'b1;
                        state_nxt = ST_IDLE;
                        if (iVALID) begin
                            start_frame = 1'b1;
                            frame_done  = (oLEN == 1);
                            state_nxt   = (oLEN == 1) ? ST_HOLD : ST_COLLECT;
                        end
                    end else if (iVALID) begin
                        ovf_set = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // score buffer, running argmax and registered result
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int i = 0; i < oLEN; i++) score_buf[i] <= '0;
            cnt     <= '0;
            run_max <= '0;
            run_idx <= '0;
            oVALID  <= 1'b0;
            oCLASS  <= '0;
            oMAX    <= '0;
            oOVF    <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            run_sec <= '0;
            oMARGIN <= '0;
`endif
        end else if (iCLR) begin
            cnt    <= '0;
            oVALID <= 1'b0;
            oOVF   <= 1'b0;
        end else begin
            if (start_frame) begin
                score_buf[0] <= iDATA;
                run_max      <= $signed(iDATA);
                run_idx      <= '0;
                cnt          <= CNTW'(1);
`ifdef ARGMAX_MARGIN_EN
                run_sec      <= SCORE_MIN;
`endif
            end
            if (accept) begin
                score_buf[cnt[IDXW-1:0]] <= iDATA;
                cnt     <= cnt + CNTW'(1);
                run_max <= fin_max;
                run_idx <= fin_idx;
`ifdef ARGMAX_MARGIN_EN
                run_sec <= fin_sec;
`endif
            end
            if (frame_done) begin
                oVALID <= 1'b1;
                oCLASS <= fin_idx;
                oMAX   <= fin_max;
`ifdef ARGMAX_MARGIN_EN
                oMARGIN <= fin_margin;
`endif
            end else if (ack_take) begin
                oVALID <= 1'b0;
            end
            if (ovf_set) oOVF <= 1'b1;
        end
    end

    // combinational readout; addresses past the frame read as zero
    always_comb begin
        oRDATA = '0;
        if ({1'b0, iRADDR} < CNTW'(oLEN)) oRDATA = score_buf[iRADDR];
    end

endmodule

// File: tb/tb_fc_result_argmax.sv
// Scoreboard bench for fc_result_argmax: the stimulus side keeps a frame-level
// model and queues expected results; a negedge monitor pops and compares.
module tb_fc_result_argmax;

    localparam int WLC  = 13;
    localparam int OLEN = 5;
    localparam int IDXW = 3;

    logic            iCLK = 1'b0;
    logic            iRSTn;
    logic            iCLR;
    logic            iVALID;
    logic [WLC-1:0]  iDATA;
    logic            iACK;
    logic [IDXW-1:0] iRADDR;
    logic [WLC-1:0]  oRDATA;
    logic            oVALID;
    logic [IDXW-1:0] oCLASS;
    logic [WLC-1:0]  oMAX;
    logic            oBUSY;
    logic            oOVF;
`ifdef ARGMAX_MARGIN_EN
    logic [WLC:0]    oMARGIN;
`endif

    fc_result_argmax #(.WLc(WLC), .oLEN(OLEN), .IDXW(IDXW)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR), .iVALID(iVALID),
        .iDATA(iDATA), .iACK(iACK), .iRADDR(iRADDR), .oRDATA(oRDATA),
        .oVALID(oVALID), .oCLASS(oCLASS), .oMAX(oMAX), .oBUSY(oBUSY),
        .oOVF(oOVF)
`ifdef ARGMAX_MARGIN_EN
        , .oMARGIN(oMARGIN)
`endif
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int     cls;
        int     mx;
        int     mg;
        longint cyc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   cur;
    int     n_checks = 0;
    int     n_err = 0;
    longint cyc = 0;
    logic   prev_valid = 1'b0;

    int     m_frame[$];
    int     m_mem[8];
    bit     m_pending;
    bit     m_ovf;

    always @(posedge iCLK) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // reference: winner is the first occurrence of the maximum value;
    // margin is the winner minus the largest of the remaining scores
    function automatic exp_t ref_result(input int sc[$]);
        exp_t e;
        int   best;
        int   rest[$];
        int   second;
        best = sc[0];
        foreach (sc[i]) if (sc[i] > best) best = sc[i];
        e.cls = 0;
        for (int i = sc.size() - 1; i >= 0; i--) if (sc[i] == best) e.cls = i;
        e.mx = best;
        rest = sc;
        rest.delete(e.cls);
        if (rest.size() == 0) begin
            e.mg = 0;
        end else begin
            second = rest[0];
            foreach (rest[i]) if (rest[i] > second) second = rest[i];
            e.mg = best - second;
        end
        e.cyc = 0;
        return e;
    endfunction

    function automatic int sx(input logic [WLC-1:0] v);
        return int'($signed(v));
    endfunction

    // one clock of stimulus; called at a negedge, returns at the next negedge
    task automatic drive(input bit v, input int d, input bit a, input bit c);
        exp_t e;
        iVALID = v;
        iDATA  = d[WLC-1:0];
        iACK   = a;
        iCLR   = c;
        #1;
        chk("rdata_pre_edge", sx(oRDATA), (int'(iRADDR) < OLEN) ? m_mem[iRADDR] : 0);
        @(posedge iCLK);
        #1;
        iVALID = 1'b0;
        iACK   = 1'b0;
        iCLR   = 1'b0;
        if (c) begin
            m_frame.delete();
            m_pending = 0;
            m_ovf     = 0;
        end else begin
            if (m_pending && a) m_pending = 0;
            if (v) begin
                if (m_pending) begin
                    m_ovf = 1;
                end else begin
                    m_mem[m_frame.size()] = d;
                    m_frame.push_back(d);
                    if (m_frame.size() == OLEN) begin
                        e = ref_result(m_frame);
                        e.cyc = cyc;
                        exp_q.push_back(e);
                        m_pending = 1;
                        m_frame.delete();
                    end
                end
            end
        end
        @(negedge iCLK);
        chk("valid", int'(oVALID), int'(m_pending));
        chk("busy", int'(oBUSY), int'(m_frame.size() > 0));
        chk("ovf", int'(oOVF), int'(m_ovf));
    endtask

    task automatic send_frame(input int s0, input int s1, input int s2,
                              input int s3, input int s4);
        int sc[5];
        sc = '{s0, s1, s2, s3, s4};
        foreach (sc[i]) drive(1, sc[i], 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, int'(oVALID), 0);
        chk({tag, "_class"}, int'(oCLASS), 0);
        chk({tag, "_max"}, sx(oMAX), 0);
        chk({tag, "_busy"}, int'(oBUSY), 0);
        chk({tag, "_ovf"}, int'(oOVF), 0);
        chk({tag, "_rdata"}, sx(oRDATA), 0);
`ifdef ARGMAX_MARGIN_EN
        chk({tag, "_margin"}, int'(oMARGIN), 0);
`endif
    endtask

    task automatic model_reset();
        m_frame.delete();
        m_pending = 0;
        m_ovf     = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
    endtask

    task automatic read_chk(input int addr);
        @(negedge iCLK);
        iRADDR = addr[IDXW-1:0];
        #1;
        chk($sformatf("rdata[%0d]", addr), sx(oRDATA), (addr < OLEN) ? m_mem[addr] : 0);
    endtask

    function automatic int rand_score();
        case ($urandom_range(0, 4))
            0:       return -4096;
            1:       return 4095;
            2:       return int'($urandom_range(0, 6)) - 3;
            default: return int'($urandom_range(0, 8191)) - 4096;
        endcase
    endfunction

    // monitor: a new result is compared on oVALID rising, then held stable
    always @(negedge iCLK) begin
        if (iRSTn) begin
            if (oVALID && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_result: class=%0d max=%0d with no expected entry",
                             oCLASS, sx(oMAX));
                end else begin
                    cur = exp_q.pop_front();
                    chk("res_class", int'(oCLASS), cur.cls);
                    chk("res_max", sx(oMAX), cur.mx);
                    chk("res_latency", int'(cyc - cur.cyc), 0);
`ifdef ARGMAX_MARGIN_EN
                    chk("res_margin", int'(oMARGIN), cur.mg);
`endif
                end
            end else if (oVALID) begin
                chk("hold_class", int'(oCLASS), cur.cls);
                chk("hold_max", sx(oMAX), cur.mx);
            end
        end
        prev_valid = oVALID;
    end

    initial begin
        iRSTn = 1'b0; iCLR = 1'b0; iVALID = 1'b0; iDATA = '0; iACK = 1'b0; iRADDR = '0;
        model_reset();
        repeat (2) @(negedge iCLK);
        check_all_zero("reset");
        iRSTn = 1'b1;
        @(negedge iCLK);

        // distinct scores, result held without ack
        send_frame(10, -3, 250, 7, 249);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        // stray strobe while pending is dropped and flagged
        drive(1, 99, 0, 0);
        drive(0, 0, 0, 0);
        chk("ovf_class", int'(oCLASS), 2);
        chk("ovf_max", sx(oMAX), 250);
        drive(0, 0, 1, 0);
        chk("after_ack_valid", int'(oVALID), 0);
        chk("after_ack_keep_max", sx(oMAX), 250);
        drive(0, 0, 0, 1);

        // ties at the extremes, then ack overlapping the next frame's first score
        send_frame(-4096, -4096, -5, -5, -4096);
        read_chk(4);
        read_chk(6);
        iRADDR = '0;
        drive(1, 5, 1, 0);
        drive(1, 4, 0, 0);
        drive(1, 3, 0, 0);
        drive(1, 2, 0, 0);
        drive(1, 1, 0, 0);
        drive(0, 0, 1, 0);

        // clear aborts a partial frame, buffer is retained
        drive(1, 100, 0, 0);
        drive(1, 200, 0, 0);
        drive(1, 300, 0, 0);
        drive(0, 0, 0, 1);
        read_chk(2);
        send_frame(1, 2, 3, 4, 4095);
        drive(0, 0, 1, 0);

        // asynchronous reset mid-frame
        drive(1, 17, 0, 0);
        drive(1, 18, 0, 0);
        #2;
        iRSTn = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge iCLK);
        iRSTn = 1'b1;
        send_frame(-7, 33, 33, -100, 12);
        drive(0, 0, 1, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit v, a, c;
            iRADDR = IDXW'($urandom_range(0, 7));
            v = ($urandom_range(0, 3) != 0);
            a = m_pending ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 80) == 0);
            drive(v, rand_score(), a, c);
        end
        for (int k = 0; k < 8; k++) read_chk(k);

        repeat (3) @(negedge iCLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_results: %0d expected results never presented", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fc_result_argmax.md
Name: fc_result_argmax

Overview:
Downstream stage of the BNN FC layer. Collects the oLEN signed 13-bit class scores that the FC stage emits one per end pulse, and computes the running argmax. It presents the winning class index and score, with all buffered scores, to the SPI output path using a valid/ack handshake. One frame corresponds to one inference.

Parameters:
WLc, 13, score width (signed two's complement)
oLEN, 5, scores per frame (number of classes)
IDXW, 3, class index width; must satisfy 2^IDXW >= oLEN

Ports:
iCLK  in  1  FPGA clock, all logic on rising edge
iRSTn  in  1  asynchronous active-low reset
iCLR  in  1  synchronous frame clear; aborts any partial frame
iVALID  in  1  one-cycle strobe: iDATA holds the next score (FC end pulse)
iDATA  in  WLc  signed score; class index is implied by arrival order
iACK  in  1  consumer has taken the result
iRADDR  in  IDXW  score buffer read index
oRDATA  out  WLc  buffered score at iRADDR (combinational read)
oVALID  out  1  result available; held high until acknowledged
oCLASS  out  IDXW  argmax class index
oMAX  out  WLc  score of the winning class
oBUSY  out  1  frame partially received
oOVF  out  1  sticky: score arrived while the result was pending

Behaviour:
- Reset (iRSTn=0, asynchronous): all outputs 0, score buffer 0, count 0, state IDLE.
- States:
  - IDLE: waiting for the first score.
  - COLLECT: scores 1..oLEN-1 received, more expected.
  - HOLD: result valid, awaiting iACK.
- IDLE, iVALID: buffer[0]=iDATA, run_max=iDATA, run_idx=0, cnt=1, go to COLLECT.
  - If oLEN=1, go directly to HOLD instead.
- COLLECT, iVALID: buffer[cnt]=iDATA.
  - If iDATA > run_max (signed, strictly greater), update run_max=iDATA and run_idx=cnt.
  - On the score that makes cnt reach oLEN: go to HOLD.
- Entry to HOLD: on the next edge, oVALID=1 and oCLASS/oMAX take the final values, including the last score. Latency from the last iVALID to oVALID is 1 cycle.
- Ties: the lowest index wins, because updates require strictly greater.
- Extreme values: -4096 and +4095 are compared correctly; no arithmetic overflow is possible with compare-only logic.
- HOLD:
  - oVALID, oCLASS and oMAX are stable until iACK is sampled high.
  - iACK=1: oVALID=0 next cycle, go to IDLE. oCLASS, oMAX and the buffer keep their values until the next frame overwrites them.
  - iVALID with iACK=0: the score is dropped, oOVF is set, and the result is unchanged.
  - iVALID and iACK in the same cycle: the ack is processed and the score starts a new frame, as if in IDLE.
- iACK outside HOLD: ignored.
- oBUSY is high exactly in COLLECT.
- iCLR: count=0, state IDLE, oVALID=0, oOVF=0; buffer contents are retained.
  - iCLR has priority over a simultaneous iVALID, which is dropped.
- oRDATA: iRADDR >= oLEN returns 0.
- Write and read of the same index in the same cycle: oRDATA returns the old value.

Optional Feature:
Macro: ARGMAX_MARGIN_EN.
- Defined:
  - Adds output oMARGIN, width WLc+1, unsigned. It equals best score minus second-best score, both taken as signed.
  - Second-best is tracked in parallel. When the best is replaced, the old best becomes the second. Otherwise, a score > run_second (strict) replaces run_second.
  - oMARGIN is valid with oVALID, reset value 0.
  - With oLEN=1, oMARGIN is 0.
- Undefined: no port, no second-best logic; all other behaviour is identical.

Test Plan:
- Scores {10,-3,250,7,249}, iACK held 0 -> oVALID=1 exactly 1 cycle after the 5th strobe, oCLASS=2, oMAX=250; with the macro defined, oMARGIN=1.
- Scores {-4096,-4096,-5,-5,-4096} -> oCLASS=2 (lowest index on tie), oMAX=-5; iRADDR=4 reads -4096, iRADDR=6 reads 0.
- While in HOLD, one extra strobe of 99 -> oOVF=1, oCLASS/oMAX unchanged. Then iACK -> oVALID=0 next cycle. Then iCLR -> oOVF=0.
- iACK together with the first strobe of the next frame {5,4,3,2,1} -> no strobe lost; second result oCLASS=0, oMAX=5.
- iCLR after 3 scores, then a full frame {1,2,3,4,4095} -> oBUSY drops on iCLR; result oCLASS=4, oMAX=4095.
- iRSTn pulsed low mid-frame, asynchronously between edges -> all outputs 0 immediately; the next full frame produces the correct argmax.
